// File: rtl/aer_merger_pkg.sv
// Shared types and helpers for the multi-channel AER input merger.
package aer_merger_pkg;

  typedef enum logic [1:0] {IDLE, PEND, ACK_HI} ch_state_t;
  typedef enum logic [1:0] {O_IDLE, O_REQ, O_WAIT_LO} out_state_t;

  // Channel-id width; never zero so the id field always exists.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is refused when full, even alongside a pop.
module aer_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/aer_multi_merger.sv
// Merges N_CH asynchronous 4-phase AER inputs round-robin through a FIFO onto one
// 4-phase AER output carrying {channel_id, addr}.
module aer_multi_merger
  import aer_merger_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W       = clog2_min1(N_CH)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [N_CH*ADDR_W-1:0]   AERIN_ADDR,
  input  logic [N_CH-1:0]          AERIN_REQ,
  output logic [N_CH-1:0]          AERIN_ACK,
  output logic [CH_W+ADDR_W-1:0]   AEROUT_ADDR,
  output logic                     AEROUT_REQ,
  input  logic                     AEROUT_ACK,
  output logic                     FIFO_FULL,
  output logic [$clog2(DEPTH):0]   FIFO_LEVEL
);

  localparam int OW = CH_W + ADDR_W;

  logic [N_CH-1:0]   req_s, pend, gnt;
  logic [CH_W-1:0]   ptr_q, ptr_d, gnt_idx;
  logic [ADDR_W-1:0] gnt_addr;
  logic [OW-1:0]     fifo_dout;
  logic              fifo_full, fifo_empty, push, pop;

  // Per-channel REQ synchroniser and 4-phase handshake FSM.
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    ch_state_t              st_q;
    logic                   ack_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], AERIN_REQ[c]};
    end
    assign req_s[c] = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        st_q  <= IDLE;
        ack_q <= 1'b0;
      end else begin
        case (st_q)
          IDLE:    if (req_s[c]) st_q <= PEND;
          PEND:    if (gnt[c]) begin
                     st_q  <= ACK_HI;
                     ack_q <= 1'b1;
                   end
          ACK_HI:  if (!req_s[c]) begin
                     st_q  <= IDLE;
                     ack_q <= 1'b0;
                   end
          default: begin
                     st_q  <= IDLE;
                     ack_q <= 1'b0;
                   end
        endcase
      end
    end

    assign pend[c]      = (st_q == PEND);
    assign AERIN_ACK[c] = ack_q;
  end

  // Round-robin: first PEND channel at or after ptr; nothing granted while full.
  always_comb begin : p_arb
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_addr = '0;
    ptr_d    = ptr_q;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr_q) + k) % N_CH;
      if (!found && !fifo_full && pend[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = CH_W'(idx);
        gnt_addr = AERIN_ADDR[idx*ADDR_W +: ADDR_W];
        ptr_d    = CH_W'((idx + 1) % N_CH);
      end
    end
  end

  assign push = |gnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  aer_sync_fifo #(.WIDTH(OW), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   ({gnt_idx, gnt_addr}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LEVEL)
  );

  assign FIFO_FULL = fifo_full;

  // Output side: ACK synchroniser and 4-phase sender.
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  out_state_t             o_st_q;
  logic                   out_req_q;
  logic [OW-1:0]          out_addr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ack_sync_q <= '0;
    else        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], AEROUT_ACK};
  end
  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  assign pop = (o_st_q == O_IDLE) && !fifo_empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_st_q     <= O_IDLE;
      out_req_q  <= 1'b0;
      out_addr_q <= '0;
    end else begin
      case (o_st_q)
        O_IDLE:    if (!fifo_empty) begin
                     out_addr_q <= fifo_dout;
                     out_req_q  <= 1'b1;
                     o_st_q     <= O_REQ;
                   end
        O_REQ:     if (ack_s) begin
                     out_req_q <= 1'b0;
                     o_st_q    <= O_WAIT_LO;
                   end
        O_WAIT_LO: if (!ack_s) o_st_q <= O_IDLE;
        default:   begin
                     out_req_q <= 1'b0;
                     o_st_q    <= O_IDLE;
                   end
      endcase
    end
  end

  assign AEROUT_REQ  = out_req_q;
  assign AEROUT_ADDR = out_addr_q;

endmodule

// File: tb/tb_aer_multi_merger.sv
// Directed bench for aer_multi_merger: 4-phase source/sink models, an occupancy
// conservation model and an expected-event scoreboard checked every cycle.
module tb_aer_multi_merger;

  localparam int N_CH   = 4;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int SS     = 2;
  localparam int CH_W   = 2;
  localparam int OW     = CH_W + ADDR_W;

  logic                     CLK, RST_N;
  logic [N_CH*ADDR_W-1:0]   AERIN_ADDR;
  logic [N_CH-1:0]          AERIN_REQ, AERIN_ACK;
  logic [OW-1:0]            AEROUT_ADDR;
  logic                     AEROUT_REQ, AEROUT_ACK, FIFO_FULL;
  logic [$clog2(DEPTH):0]   FIFO_LEVEL;

  aer_multi_merger #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST_N(RST_N), .AERIN_ADDR(AERIN_ADDR), .AERIN_REQ(AERIN_REQ),
    .AERIN_ACK(AERIN_ACK), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ),
    .AEROUT_ACK(AEROUT_ACK), .FIFO_FULL(FIFO_FULL), .FIFO_LEVEL(FIFO_LEVEL)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0] src_q [N_CH][$];
  logic [OW-1:0]     exp_q[$];
  logic [OW-1:0]     out_log[$];
  int                gnt_log[$];
  int                gnt_cyc[$];
  int                req_cyc [N_CH];
  int                out_cyc;
  logic [N_CH-1:0]   hold;
  logic              sink_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] ev(input int c, input int a);
    return {CH_W'(c), ADDR_W'(a)};
  endfunction

  function automatic bit all_src_empty();
    for (int c = 0; c < N_CH; c++) if (src_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Input sources: raise REQ with the next queued address, drop it once ACK is seen.
  initial begin
    AERIN_REQ  = '0;
    AERIN_ADDR = '0;
    forever begin
      @(negedge CLK);
      for (int c = 0; c < N_CH; c++) begin
        if (AERIN_REQ[c] && AERIN_ACK[c] && !hold[c]) AERIN_REQ[c] = 1'b0;
        else if (!AERIN_REQ[c] && !AERIN_ACK[c] && src_q[c].size() != 0) begin
          AERIN_ADDR[c*ADDR_W +: ADDR_W] = src_q[c].pop_front();
          AERIN_REQ[c] = 1'b1;
          req_cyc[c]   = cyc;
        end
      end
    end
  end

  // Output sink: completes the 4-phase handshake when enabled.
  initial begin
    AEROUT_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (sink_en) begin
        if (AEROUT_REQ && !AEROUT_ACK)      AEROUT_ACK = 1'b1;
        else if (!AEROUT_REQ && AEROUT_ACK) AEROUT_ACK = 1'b0;
      end
    end
  end

  // Model: occupancy = accepted events (ACK rises) - emitted events (REQ rises);
  // emitted events must follow exp_q and hold their address while REQ is high.
  int            n_push, n_pop;
  logic [N_CH-1:0] prev_ack;
  logic          prev_req;
  logic [OW-1:0] prev_addr;

  always @(negedge CLK) begin
    if (!RST_N) begin
      n_push = 0; n_pop = 0; prev_ack = '0; prev_req = 1'b0; prev_addr = '0;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (AERIN_ACK[c] && !prev_ack[c]) begin
          n_push++;
          gnt_log.push_back(c);
          gnt_cyc.push_back(cyc);
        end
      if (AEROUT_REQ && !prev_req) begin
        n_pop++;
        out_log.push_back(AEROUT_ADDR);
        out_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got 0x%0h expected no event", AEROUT_ADDR);
        end else check("out_order", AEROUT_ADDR, exp_q.pop_front());
      end
      if (AEROUT_REQ && prev_req) check("out_hold", AEROUT_ADDR, prev_addr);
      check("level_model", FIFO_LEVEL, n_push - n_pop);
      check("full_model", FIFO_FULL, 32'((n_push - n_pop) == DEPTH));
      prev_ack = AERIN_ACK; prev_req = AEROUT_REQ; prev_addr = AEROUT_ADDR;
    end
  end

  task automatic apply_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete(); out_log.delete(); gnt_log.delete(); gnt_cyc.delete();
    for (int c = 0; c < N_CH; c++) src_q[c].delete();
    RST_N = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK); #1;
      if (exp_q.size() == 0 && all_src_empty() && AERIN_REQ == '0 && AERIN_ACK == '0 &&
          !AEROUT_REQ && !AEROUT_ACK) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 1);
  endtask

  logic [OW-1:0] cont_lit [4];

  initial begin
    RST_N = 1'b0; sink_en = 1'b1; hold = '0;
    repeat (3) @(negedge CLK);
    check("rst_ack", AERIN_ACK, 0);
    check("rst_oreq", AEROUT_REQ, 0);
    check("rst_oaddr", AEROUT_ADDR, 0);
    check("rst_level", FIFO_LEVEL, 0);
    check("rst_full", FIFO_FULL, 0);
    RST_N = 1'b1;

    // Single event on ch2
    @(posedge CLK);
    src_q[2].push_back(10'h155);
    exp_q.push_back(ev(2, 'h155));
    wait_done(100, "single");
    check("single_count", out_log.size(), 1);
    check("single_addr", out_log[0], 12'h955);
    check("single_latency", out_cyc - req_cyc[2], SS + 3);
    check("single_ack_ch", (gnt_log.size() == 1) ? gnt_log[0] : -1, 2);

    // Contention from a fresh pointer
    apply_reset();
    @(posedge CLK);
    for (int c = 0; c < N_CH; c++) begin
      src_q[c].push_back(ADDR_W'(c));
      exp_q.push_back(ev(c, c));
    end
    wait_done(200, "cont");
    cont_lit = '{12'h000, 12'h401, 12'h802, 12'hC03};
    check("cont_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) check("cont_lit", out_log[i], cont_lit[i]);
    check("cont_ngnt", gnt_cyc.size(), 4);
    for (int i = 0; i < 3; i++) check("cont_spacing", gnt_cyc[i+1] - gnt_cyc[i], 1);
    out_log.delete();
    @(posedge CLK);
    src_q[0].push_back(10'h0AA); exp_q.push_back(ev(0, 'h0AA));
    src_q[3].push_back(10'h0BB); exp_q.push_back(ev(3, 'h0BB));
    wait_done(200, "cont2");
    check("cont2_first", out_log[0], 12'h0AA);
    check("cont2_second", out_log[1], 12'hCBB);

    // Backpressure: 12 events with the sink stalled
    apply_reset();
    sink_en = 1'b0;
    @(posedge CLK);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < N_CH; c++) begin
        src_q[c].push_back(ADDR_W'((k << 4) | c));
        exp_q.push_back(ev(c, (k << 4) | c));
      end
    repeat (60) @(negedge CLK);
    check("bp_full", FIFO_FULL, 1);
    check("bp_level", FIFO_LEVEL, DEPTH);
    check("bp_grants", gnt_log.size(), 9);
    check("bp_ack_low", AERIN_ACK[3:1], 0);
    check("bp_req_held", AERIN_REQ[3:1], 3'b111);
    check("bp_out_one", out_log.size(), 1);
    sink_en = 1'b1;
    wait_done(600, "bp");
    check("bp_count", out_log.size(), 12);
    check("bp_fifth", out_log[4], 12'h010);
    check("bp_last", out_log[11], 12'hC23);

    // Pointer wrap: 20 back-to-back events on ch1
    apply_reset();
    @(posedge CLK);
    for (int i = 0; i < 20; i++) begin
      src_q[1].push_back(ADDR_W'(10'h3A0 + i));
      exp_q.push_back(ev(1, 10'h3A0 + i));
    end
    wait_done(1000, "wrap");
    check("wrap_count", out_log.size(), 20);
    check("wrap_last", out_log[19], 12'h7B3);

    // Reset mid-handshake with ch1 holding REQ
    apply_reset();
    sink_en = 1'b0;
    hold[1] = 1'b1;
    @(posedge CLK);
    for (int c = 0; c < N_CH; c++) begin
      src_q[c].push_back(ADDR_W'(10'h2A0 + c));
      exp_q.push_back(ev(c, 10'h2A0 + c));
    end
    repeat (40) @(negedge CLK);
    check("mid_oreq", AEROUT_REQ, 1);
    check("mid_level", FIFO_LEVEL, 3);
    check("mid_oaddr", AEROUT_ADDR, 12'h2A0);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("arst_oreq", AEROUT_REQ, 0);
    check("arst_oaddr", AEROUT_ADDR, 0);
    check("arst_ack", AERIN_ACK, 0);
    check("arst_level", FIFO_LEVEL, 0);
    check("arst_full", FIFO_FULL, 0);
    exp_q.delete(); out_log.delete();
    repeat (2) @(negedge CLK);
    exp_q.push_back(ev(1, 10'h2A1));
    RST_N = 1'b1;
    sink_en = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge CLK); #1;
        if (out_log.size() != 0) begin seen = 1'b1; break; end
      end
      check("post_event_seen", 32'(seen), 1);
    end
    hold[1] = 1'b0;
    wait_done(200, "post");
    repeat (40) @(negedge CLK);
    check("post_count", out_log.size(), 1);
    check("post_addr", out_log[0], 12'h6A1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
